// File: rtl/inv_sub_bytes_seq.sv
// inv_sub_bytes_seq: sequential AES InvSubBytes engine.
// Substitutes LANES bytes per clock through an arithmetic inverse S-box
// (inverse affine transform followed by the GF(2^8) inverse). The working
// register is rotated right by LANES bytes each cycle. The freshly substituted
// bytes re-enter at the top, so after 16/LANES cycles every byte is back in
// its original position.
module inv_sub_bytes_seq #(
    parameter int LANES = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] instate,
    output logic [127:0] outstate,
    output logic         busy,
    output logic         done
);

    // Reject unsupported lane counts while the design is being elaborated.
    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
        $error("inv_sub_bytes_seq: LANES must be 1, 2, 4, 8 or 16");
    end

    localparam logic [4:0] LAST = 5'(16 - LANES);
    localparam logic [4:0] STEP = 5'(LANES);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t              r_state;
    logic [4:0]          r_cnt;
    logic [127:0]        r_work;
    logic [127:0]        r_out;
    logic                r_busy;
    logic                r_done;
    logic [8*LANES-1:0]  w_sub;
    logic [127:0]        w_next;

    // GF(2^8) multiply, reduced mod x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // x^254 as the product x^2 * x^4 * ... * x^128; zero maps to zero naturally.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] res;
        sq  = x;
        res = 8'h01;
        for (int i = 0; i < 7; i++) begin
            sq  = gf_mul(sq, sq);
            res = gf_mul(res, sq);
        end
        return res;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        logic [7:0] c;
        for (int i = 0; i < 8; i++) begin
            c[i] = b[(i + 2) % 8] ^ b[(i + 5) % 8] ^ b[(i + 7) % 8];
        end
        return gf_inv(c ^ 8'h05);
    endfunction

    // Substitute the bottom LANES bytes of the working register.
    always_comb begin
        w_sub = '0;
        for (int l = 0; l < LANES; l++) begin
            w_sub[8*l +: 8] = inv_sbox(r_work[8*l +: 8]);
        end
    end

    // Rotate: substituted bytes go to the top, the rest shift down.
    if (LANES == 16) begin : g_full
        assign w_next = w_sub;
    end else begin : g_rot
        assign w_next = {w_sub, r_work[127:8*LANES]};
    end

    // Control FSM with registered busy/done and result register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_work  <= '0;
            r_out   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_work  <= instate;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_work <= w_next;
                    if (r_cnt == LAST) begin
                        r_out   <= w_next;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_cnt   <= '0;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + STEP;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign outstate = r_out;
    assign busy     = r_busy;
    assign done     = r_done;

endmodule

// File: tb/tb_inv_sub_bytes_seq.sv
// Testbench for inv_sub_bytes_seq: one instance per legal LANES value, all
// sharing stimulus. Instance 0 (LANES=1) carries the directed tests. The
// reference inverse S-box is built by inverting a forward S-box whose GF
// inverse is found by exhaustive search.
module tb_inv_sub_bytes_seq;

    logic         clk;
    logic         rst;
    logic         start;
    logic [127:0] instate;
    logic [127:0] w_out  [5];
    logic         w_busy [5];
    logic         w_done [5];

    int checks;
    int failures;

    logic [7:0]   sbox [256];
    logic [7:0]   invs [256];
    logic [127:0] last_exp;

    for (genvar g = 0; g < 5; g++) begin : g_dut
        inv_sub_bytes_seq #(.LANES(1 << g)) u_dut (
            .clk      (clk),
            .rst      (rst),
            .start    (start),
            .instate  (instate),
            .outstate (w_out[g]),
            .busy     (w_busy[g]),
            .done     (w_done[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r;
        logic [7:0] x;
        logic [7:0] y;
        r = 8'h00;
        x = a;
        y = b;
        while (y != 8'h00) begin
            if (y[0]) r = r ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
            y = y >> 1;
        end
        return r;
    endfunction

    task automatic build_tables();
        logic [7:0] x;
        logic [7:0] y;
        logic [7:0] s;
        logic [7:0] c63;
        c63 = 8'h63;
        for (int v = 0; v < 256; v++) begin
            x = 8'(v);
            y = 8'h00;
            for (int c = 1; c < 256; c++) begin
                if (m_mul(x, 8'(c)) == 8'h01) y = 8'(c);
            end
            for (int i = 0; i < 8; i++) begin
                s[i] = y[i] ^ y[(i + 4) % 8] ^ y[(i + 5) % 8] ^ y[(i + 6) % 8] ^ y[(i + 7) % 8] ^ c63[i];
            end
            sbox[v] = s;
            invs[s] = x;
        end
    endtask

    function automatic logic [127:0] m_inv_state(input logic [127:0] s);
        logic [127:0] r;
        for (int k = 0; k < 16; k++) r[8*k +: 8] = invs[s[8*k +: 8]];
        return r;
    endfunction

    function automatic logic [127:0] m_fwd_state(input logic [127:0] s);
        logic [127:0] r;
        for (int k = 0; k < 16; k++) r[8*k +: 8] = sbox[s[8*k +: 8]];
        return r;
    endfunction

    function automatic logic [127:0] rand_state();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Pulse start for one edge and wait (bounded) for instance 0 to finish.
    task automatic do_run(input logic [127:0] st, output logic [127:0] res, output int lat);
        res     = '0;
        lat     = -1;
        instate = st;
        start   = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            if (w_done[0]) begin
                lat = c;
                res = w_out[0];
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 8; i++) begin
            instate = rand_state();
            start   = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            for (int g = 0; g < 5; g++) begin
                checks++;
                if ({w_out[g], w_busy[g], w_done[g]} !== 130'd0) begin
                    failures++;
                    $display("FAIL reset_hold lanes=%0d: out=%h busy=%b done=%b want all zero",
                             1 << g, w_out[g], w_busy[g], w_done[g]);
                end
            end
        end
        start = 1'b0;
        rst   = 1'b0;
        last_exp = '0;
        @(posedge clk); #1;
    endtask

    task automatic test_known();
        logic [127:0] vin  [3];
        logic [127:0] vexp [3];
        logic [127:0] res;
        int lat;
        vin[0]  = 128'h0f0e0d0c0b0a09080706050403020100;
        vexp[0] = 128'hfbd7f3819ea340bf38a53630d56a0952;
        vin[1]  = {16{8'h63}};
        vexp[1] = '0;
        vin[2]  = {16{8'h16}};
        vexp[2] = {16{8'hff}};
        for (int t = 0; t < 3; t++) begin
            do_run(vin[t], res, lat);
            checks++;
            if (lat !== 16) begin
                failures++;
                $display("FAIL known_latency vec=%0d: got %0d want 16", t, lat);
            end
            checks++;
            if (res !== vexp[t]) begin
                failures++;
                $display("FAIL known_value vec=%0d: got %h want %h", t, res, vexp[t]);
            end
            last_exp = vexp[t];
        end
    endtask

    task automatic test_exhaustive();
        logic [127:0] st;
        logic [127:0] res;
        int lat;
        for (int r = 0; r < 16; r++) begin
            for (int k = 0; k < 16; k++) st[8*k +: 8] = 8'(16 * r + k);
            do_run(st, res, lat);
            checks++;
            if (res !== m_inv_state(st)) begin
                failures++;
                $display("FAIL exhaustive_model run=%0d: got %h want %h", r, res, m_inv_state(st));
            end
            checks++;
            if (m_fwd_state(res) !== st) begin
                failures++;
                $display("FAIL exhaustive_roundtrip run=%0d: subbytes(out)=%h want %h", r, m_fwd_state(res), st);
            end
            last_exp = m_inv_state(st);
        end
    endtask

    task automatic test_handshake();
        logic [127:0] st;
        logic [127:0] exp_v;
        st    = rand_state();
        exp_v = m_inv_state(st);
        instate = st;
        start   = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 1; c <= 16; c++) begin
            @(posedge clk); #1;
            checks++;
            if (w_busy[0] !== (c < 16) || w_done[0] !== (c == 16)) begin
                failures++;
                $display("FAIL handshake_flags cycle=%0d: busy=%b done=%b want busy=%b done=%b",
                         c, w_busy[0], w_done[0], c < 16, c == 16);
            end
            if (c < 16) begin
                checks++;
                if (w_out[0] !== last_exp) begin
                    failures++;
                    $display("FAIL handshake_hold cycle=%0d: got %h want %h", c, w_out[0], last_exp);
                end
            end
            if (c == 4) start = 1'b1;
            if (c == 5) start = 1'b0;
            if (c == 8) instate = ~st;
        end
        checks++;
        if (w_out[0] !== exp_v) begin
            failures++;
            $display("FAIL handshake_result: got %h want %h", w_out[0], exp_v);
        end
        @(posedge clk); #1;
        checks++;
        if (w_done[0] !== 1'b0 || w_busy[0] !== 1'b0) begin
            failures++;
            $display("FAIL handshake_after: busy=%b done=%b want 0 0", w_busy[0], w_done[0]);
        end
        instate  = st;
        last_exp = exp_v;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        logic [127:0] v [4];
        int lat;
        for (int i = 0; i < 4; i++) v[i] = rand_state();
        instate = v[0];
        start   = 1'b1;
        @(posedge clk); #1;
        instate = v[1];
        for (int k = 0; k < 4; k++) begin
            lat = -1;
            for (int c = 1; c <= 20; c++) begin
                @(posedge clk); #1;
                if (w_done[0]) begin
                    lat = c;
                    break;
                end
            end
            checks++;
            if (lat !== 16) begin
                failures++;
                $display("FAIL b2b_latency run=%0d: got %0d want 16", k, lat);
            end
            checks++;
            if (w_out[0] !== m_inv_state(v[k])) begin
                failures++;
                $display("FAIL b2b_value run=%0d: got %h want %h", k, w_out[0], m_inv_state(v[k]));
            end
            if (k == 3) begin
                start = 1'b0;
            end else begin
                @(posedge clk); #1;
                checks++;
                if (w_busy[0] !== 1'b1) begin
                    failures++;
                    $display("FAIL b2b_accept run=%0d: busy=%b want 1", k, w_busy[0]);
                end
                if (k < 2) instate = v[k + 2];
            end
        end
        last_exp = m_inv_state(v[3]);
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid_run();
        logic [127:0] res;
        logic         seen_done;
        int lat;
        instate = rand_state();
        start   = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        checks++;
        if (w_busy[0] !== 1'b1) begin
            failures++;
            $display("FAIL midrst_pre_busy: busy=%b want 1", w_busy[0]);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (w_busy[0] !== 1'b0 || w_done[0] !== 1'b0 || w_out[0] !== 128'd0) begin
            failures++;
            $display("FAIL midrst_async: busy=%b done=%b out=%h want 0 0 0", w_busy[0], w_done[0], w_out[0]);
        end
        #2 rst = 1'b0;
        seen_done = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (w_done[0]) seen_done = 1'b1;
        end
        checks++;
        if (seen_done !== 1'b0) begin
            failures++;
            $display("FAIL midrst_no_done: done pulse seen after abort, want none");
        end
        do_run(128'h0f0e0d0c0b0a09080706050403020100, res, lat);
        checks++;
        if (res !== 128'hfbd7f3819ea340bf38a53630d56a0952 || lat !== 16) begin
            failures++;
            $display("FAIL midrst_fresh_run: got %h lat=%0d want fbd7f3819ea340bf38a53630d56a0952 lat=16", res, lat);
        end
    endtask

    task automatic test_sweep();
        logic [127:0] st;
        logic [127:0] exp_v;
        logic [127:0] res [5];
        int lat [5];
        repeat (20) @(posedge clk);
        #1;
        for (int n = 0; n < 1000; n++) begin
            st    = rand_state();
            exp_v = m_inv_state(st);
            for (int g = 0; g < 5; g++) begin
                lat[g] = -1;
                res[g] = '0;
            end
            instate = st;
            start   = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            for (int c = 1; c <= 18; c++) begin
                @(posedge clk); #1;
                for (int g = 0; g < 5; g++) begin
                    if (w_done[g] && lat[g] < 0) begin
                        lat[g] = c;
                        res[g] = w_out[g];
                    end
                end
            end
            for (int g = 0; g < 5; g++) begin
                checks++;
                if (lat[g] !== (16 >> g)) begin
                    failures++;
                    $display("FAIL sweep_latency lanes=%0d iter=%0d: got %0d want %0d", 1 << g, n, lat[g], 16 >> g);
                end
                checks++;
                if (res[g] !== exp_v) begin
                    failures++;
                    $display("FAIL sweep_value lanes=%0d iter=%0d: got %h want %h", 1 << g, n, res[g], exp_v);
                end
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        start    = 1'b0;
        instate  = '0;
        last_exp = '0;
        build_tables();
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_known();
        test_exhaustive();
        test_handshake();
        test_back_to_back();
        test_reset_mid_run();
        test_sweep();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
